// File: rtl/regfile_wport_arbiter_if.sv
// Register-file write-port arbiter bus: WB and LU requesters, ID source
// lookups and the single regfile write port.
interface regfile_wport_arbiter_if;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic [4:0]  r1_addr;
    logic [4:0]  r2_addr;
    logic        r1_pending;
    logic        r2_pending;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    modport master (
        output wb_valid, wb_addr, wb_data,
        output lu_valid, lu_addr, lu_data,
        output r1_addr, r2_addr,
        input  wb_ready, lu_ready,
        input  r1_pending, r2_pending,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  lu_valid, lu_addr, lu_data,
        input  r1_addr, r2_addr,
        output wb_ready, lu_ready,
        output r1_pending, r2_pending,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Shares the regfile write port between WB and a queued long-latency unit.
// Optional REGFILE_ARB_BYPASS_EN lets an LU result skip an empty FIFO.
module regfile_wport_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input logic                    clk,
    input logic                    reset,
    regfile_wport_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [SW-1:0] starve_cnt;

    logic          empty;
    logic          full;
    logic          force_lu;
    logic          lu_rdy;
    logic          push;
    logic          enq;
    logic          pop;
    logic          wb_take;
    logic          bypass;
    logic [AW-1:0] off;
    logic          hit1;
    logic          hit2;

    always_comb begin
        empty    = (count == '0);
        full     = (count == (AW+1)'(DEPTH));
        force_lu = !empty && (starve_cnt == SW'(STARVE_MAX));
        lu_rdy   = reset && !full;
        push     = bus.lu_valid && lu_rdy;
        wb_take  = bus.wb_valid && !force_lu;
        pop      = force_lu || (!bus.wb_valid && !empty);
`ifdef REGFILE_ARB_BYPASS_EN
        bypass   = push && empty && !wb_take;
`else
        bypass   = 1'b0;
`endif
        enq      = push && !bypass;
        bus.lu_ready = lu_rdy;
        bus.wb_ready = reset && !force_lu;
    end

    // A slot is live when its distance from head is below count.
    always_comb begin
        off  = '0;
        hit1 = bus.rf_we && (bus.rf_waddr == bus.r1_addr);
        hit2 = bus.rf_we && (bus.rf_waddr == bus.r2_addr);
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - head;
            if ({1'b0, off} < count) begin
                if (q_addr[i] == bus.r1_addr) hit1 = 1'b1;
                if (q_addr[i] == bus.r2_addr) hit2 = 1'b1;
            end
        end
        bus.r1_pending = (bus.r1_addr != 5'd0) && hit1;
        bus.r2_pending = (bus.r2_addr != 5'd0) && hit2;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[tail] <= bus.lu_addr;
            q_data[tail] <= bus.lu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            starve_cnt   <= '0;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= 5'd0;
            bus.rf_wdata <= 32'd0;
        end else begin
            if (pop) head <= head + 1'b1;
            if (enq) tail <= tail + 1'b1;
            count <= count + {{AW{1'b0}}, enq} - {{AW{1'b0}}, pop};

            if (pop || empty)
                starve_cnt <= '0;
            else if (wb_take && starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + 1'b1;

            // Address 0 is consumed like any grant but never written.
            if (pop) begin
                bus.rf_we    <= (q_addr[head] != 5'd0);
                bus.rf_waddr <= q_addr[head];
                bus.rf_wdata <= q_data[head];
            end else if (wb_take) begin
                bus.rf_we    <= (bus.wb_addr != 5'd0);
                bus.rf_waddr <= bus.wb_addr;
                bus.rf_wdata <= bus.wb_data;
            end else if (bypass) begin
                bus.rf_we    <= (bus.lu_addr != 5'd0);
                bus.rf_waddr <= bus.lu_addr;
                bus.rf_wdata <= bus.lu_data;
            end else begin
                bus.rf_we    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Bench for regfile_wport_arbiter: directed steps then random traffic,
// checked every cycle against a queue-based reference model.
module tb_regfile_wport_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clk;
    logic reset;
    regfile_wport_arbiter_if bus ();

    regfile_wport_arbiter #(
        .DEPTH     (DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    ent_t        q[$];
    int          starve = 0;
    logic        m_we = 1'b0;
    logic [4:0]  m_wa = 5'd0;
    logic [31:0] m_wd = 32'd0;
    bit          known = 1'b0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic pend(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (m_we && m_wa == r) return 1'b1;
        foreach (q[i]) if (q[i].a == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cyc(input logic rst,
                       input logic wv, input logic [4:0] wa,
                       input logic [31:0] wd,
                       input logic lv, input logic [4:0] la,
                       input logic [31:0] ld,
                       input logic [4:0] r1, input logic [4:0] r2);
        int   size;
        bit   full;
        bit   force_lu;
        bit   enq;
        bit   wbg;
        bit   popg;
        ent_t e;
        reset        = rst;
        bus.wb_valid = wv;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
        bus.lu_valid = lv;
        bus.lu_addr  = la;
        bus.lu_data  = ld;
        bus.r1_addr  = r1;
        bus.r2_addr  = r2;
        #2;
        size     = q.size();
        full     = (size == DEPTH);
        force_lu = rst && size != 0 && starve == STARVE_MAX;
        chk("wb_ready", bus.wb_ready, rst && !force_lu);
        chk("lu_ready", bus.lu_ready, rst && !full);
        if (known) begin
            chk("r1_pending", bus.r1_pending, pend(r1));
            chk("r2_pending", bus.r2_pending, pend(r2));
        end
        @(posedge clk);
        known = 1'b1;
        if (!rst) begin
            q.delete();
            starve = 0;
            m_we = 1'b0;
            m_wa = 5'd0;
            m_wd = 32'd0;
        end else begin
            enq  = lv && !full;
            wbg  = wv && !force_lu;
            popg = force_lu || (!wv && size != 0);
            if (popg) begin
                e = q.pop_front();
                m_we = (e.a != 0);
                m_wa = e.a;
                m_wd = e.d;
            end else if (wbg) begin
                m_we = (wa != 0);
                m_wa = wa;
                m_wd = wd;
`ifdef REGFILE_ARB_BYPASS_EN
            end else if (enq && size == 0) begin
                m_we = (la != 0);
                m_wa = la;
                m_wd = ld;
                enq  = 1'b0;
`endif
            end else begin
                m_we = 1'b0;
            end
            if (popg || size == 0) starve = 0;
            else if (wbg && starve < STARVE_MAX) starve++;
            if (enq) q.push_back('{a: la, d: ld});
        end
        #1;
        chk("rf_we", bus.rf_we, m_we);
        if (m_we || !rst) begin
            chk("rf_waddr", bus.rf_waddr, m_wa);
            chk("rf_wdata", bus.rf_wdata, m_wd);
        end
    endtask

    initial begin
        // reset held with both requesters asserting
        cyc(0, 1, 5'd5, 32'h1, 1, 5'd6, 32'h2, 5'd5, 5'd6);
        cyc(0, 1, 5'd5, 32'h1, 1, 5'd6, 32'h2, 5'd5, 5'd6);
        cyc(1, 0, 0, 0, 0, 0, 0, 5'd5, 5'd6);
        // WB only, then address 0
        cyc(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 5'd5, 5'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
        cyc(1, 1, 5'd0, 32'h12345678, 0, 0, 0, 5'd0, 5'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
        // LU ordering with r1 watching register 4
        cyc(1, 0, 0, 0, 1, 5'd3, 32'h11, 5'd4, 5'd3);
        cyc(1, 0, 0, 0, 1, 5'd4, 32'h22, 5'd4, 5'd3);
        repeat (4) cyc(1, 0, 0, 0, 0, 0, 0, 5'd4, 5'd3);
        // fill the FIFO while WB is busy; third push must be refused
        cyc(1, 1, 5'd7, 32'hA0, 1, 5'd8, 32'hB0, 5'd8, 5'd9);
        cyc(1, 1, 5'd7, 32'hA1, 1, 5'd9, 32'hB1, 5'd8, 5'd9);
        cyc(1, 1, 5'd7, 32'hA2, 1, 5'd10, 32'hBAD, 5'd10, 5'd9);
        repeat (6) cyc(1, 1, 5'd7, 32'hA3, 0, 0, 0, 5'd10, 5'd8);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 5'd10, 5'd8);
        // starvation: one LU entry against continuous WB
        cyc(1, 1, 5'd1, 32'hC0, 1, 5'd2, 32'hD0, 5'd2, 5'd1);
        for (int i = 0; i < 8; i++)
            cyc(1, 1, 5'd1, 32'hC1 + i, 0, 0, 0, 5'd2, 5'd1);
        cyc(1, 0, 0, 0, 0, 0, 0, 5'd2, 5'd1);
        // bypass probe from an empty FIFO
        cyc(1, 0, 0, 0, 1, 5'd12, 32'hE0, 5'd12, 5'd0);
        repeat (3) cyc(1, 0, 0, 0, 0, 0, 0, 5'd12, 5'd0);
        // random traffic with occasional mid-run reset
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) != 0),
                1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
